syndrome_generator: RTL

//  Produces the S_LENGTH-bit LDPC syndrome s = H*c^T (GF(2)) from a codeword streamed in IN_BITS per beat.

---
 rtl/syndrome_generator_pkg.sv | 19 +
 rtl/syndrome_generator_if.sv | 35 +++
 rtl/syndrome_xor_tree.sv | 21 ++
 rtl/syndrome_generator.sv | 103 ++++++++++
 4 files changed

// File: rtl/syndrome_generator_pkg.sv
// Shared defaults, FSM state encoding and width helper for the syndrome generator.
package syndrome_generator_pkg;

  localparam int unsigned S_LENGTH_DEF = 256;
  localparam int unsigned N_LENGTH_DEF = 512;
  localparam int unsigned IN_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Beat counter width; kept at least one bit so a single-beat frame still elaborates.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/syndrome_generator_if.sv
// Codeword stream, H-column store and syndrome handshake bundle.
interface syndrome_generator_if
  import syndrome_generator_pkg::*;
#(
  parameter int unsigned S_LENGTH = S_LENGTH_DEF,
  parameter int unsigned N_LENGTH = N_LENGTH_DEF,
  parameter int unsigned IN_BITS  = IN_BITS_DEF,
  localparam int unsigned BEATS    = N_LENGTH / IN_BITS,
  localparam int unsigned CNT_BITS = cnt_width(BEATS)
);

  logic                         start;
  logic [IN_BITS-1:0]           c_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [CNT_BITS-1:0]          h_addr;
  logic [IN_BITS*S_LENGTH-1:0]  h_cols;
  logic [S_LENGTH-1:0]          s_data;
  logic                         s_valid;
  logic                         s_ready;
  logic                         s_zero;

  // Side that streams the codeword, serves H and consumes the syndrome.
  modport master (
    output start, c_data, in_valid, h_cols, s_ready,
    input  in_ready, h_addr, s_data, s_valid, s_zero
  );

  // The syndrome generator itself.
  modport slave (
    input  start, c_data, in_valid, h_cols, s_ready,
    output in_ready, h_addr, s_data, s_valid, s_zero
  );

endinterface

// File: rtl/syndrome_xor_tree.sv
// Masks the beat's H columns by the codeword bits and XOR-reduces them to one syndrome update.
module syndrome_xor_tree #(
  parameter int unsigned S_LENGTH = 256,
  parameter int unsigned IN_BITS  = 8
) (
  input  logic [IN_BITS-1:0]          c_data,
  input  logic [IN_BITS*S_LENGTH-1:0] h_cols,
  output logic [S_LENGTH-1:0]         syn
);

  // GF(2) sum of the columns selected by set codeword bits.
  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < IN_BITS; i++) begin
      if (c_data[i]) begin
        syn = syn ^ h_cols[i*S_LENGTH +: S_LENGTH];
      end
    end
  end

endmodule

// File: rtl/syndrome_generator.sv
// LDPC syndrome generator: accumulates H*c^T over a streamed codeword, then holds the result.
module syndrome_generator
  import syndrome_generator_pkg::*;
#(
  parameter int unsigned S_LENGTH = S_LENGTH_DEF,
  parameter int unsigned N_LENGTH = N_LENGTH_DEF,
  parameter int unsigned IN_BITS  = IN_BITS_DEF
) (
  input logic                 clk,
  input logic                 rst,
  syndrome_generator_if.slave bus
);

  localparam int unsigned BEATS    = N_LENGTH / IN_BITS;
  localparam int unsigned CNT_BITS = cnt_width(BEATS);
  localparam logic [CNT_BITS-1:0] LastBeat = CNT_BITS'(BEATS - 1);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [S_LENGTH-1:0] s_data_q, s_data_d;
  logic                s_zero_q, s_zero_d;
  logic [S_LENGTH-1:0] beat_syn;

  syndrome_xor_tree #(
    .S_LENGTH (S_LENGTH),
    .IN_BITS  (IN_BITS)
  ) u_xor_tree (
    .c_data (bus.c_data),
    .h_cols (bus.h_cols),
    .syn    (beat_syn)
  );

  // Next-state, beat counter and syndrome accumulation.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    s_data_d   = s_data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          s_data_d   = '0;
          beat_cnt_d = '0;
          state_d    = StAccum;
        end
      end
      StAccum: begin
        // A restart wins over any beat presented in the same cycle.
        if (bus.start) begin
          s_data_d   = '0;
          beat_cnt_d = '0;
        end else if (bus.in_valid) begin
          s_data_d = s_data_q ^ beat_syn;
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d = '0;
            state_d    = StDone;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
          end
        end
      end
      StDone: begin
        // Start is only honoured together with the consumer taking the result.
        if (bus.s_ready) begin
          if (bus.start) begin
            s_data_d   = '0;
            beat_cnt_d = '0;
            state_d    = StAccum;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        beat_cnt_d = '0;
      end
    endcase
    // Zero flag only carries meaning while the result is presented.
    s_zero_d = (state_d == StDone) && ~|s_data_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      s_data_q   <= '0;
      s_zero_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      s_data_q   <= s_data_d;
      s_zero_q   <= s_zero_d;
    end
  end

  assign bus.in_ready = (state_q == StAccum);
  assign bus.s_valid  = (state_q == StDone);
  assign bus.h_addr   = beat_cnt_q;
  assign bus.s_data   = s_data_q;
  assign bus.s_zero   = s_zero_q;

endmodule
